// File: rtl/audio_pkg.sv
// Shared definitions for the audio record/playback sequencer: default geometry
// and the controller state encoding.
package audio_pkg;

    localparam int unsigned DEPTH_DEFAULT = 125000;
    localparam int unsigned AW_DEFAULT    = 17;
    localparam int unsigned DW_DEFAULT    = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RECORD     = 3'd1,
        PLAY_WAIT  = 3'd2,
        PLAY_RD    = 3'd3,
        PLAY_LATCH = 3'd4
    } state_e;

endpackage

// File: rtl/audio_seq_ctrl_if.sv
// Single-port sample memory bus between the sequencer (master) and the
// external recording memory (slave).
interface audio_seq_ctrl_if
    import audio_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
);

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge pulse generator for an already-synchronised button level.
// Stays disarmed for the first clock after reset so no edge is taken before the second edge.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic armed_q;
    logic prev_q;

    // History is only captured once armed, so a level already high at reset
    // release still counts as an edge on the second clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (armed_q) begin
                prev_q <= level_i;
            end
        end
    end

    assign pulse_o = armed_q & level_i & ~prev_q;

endmodule

// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer: streams deserialized samples into an external
// single-port memory and replays them to the PWM stage on request.
module audio_seq_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rec_btn,
    input  logic          play_btn,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample_data,
    input  logic          pwm_req,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          deser_en,
    output logic          pwm_en,
    output logic [DW-1:0] pwm_sample,
    output logic [AW-1:0] rec_len,
    output logic          busy,
    output logic          rec_done,
    output logic          play_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE       = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rec_len_q, rec_len_d;
    logic [DW-1:0] pwm_sample_q, pwm_sample_d;
    logic          rec_edge;
    logic          play_edge;

    edge_detect u_rec_edge (
        .clk     (clk),
        .rst_n   (reset_n),
        .level_i (rec_btn),
        .pulse_o (rec_edge)
    );

    edge_detect u_play_edge (
        .clk     (clk),
        .rst_n   (reset_n),
        .level_i (play_btn),
        .pulse_o (play_edge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rec_len_q    <= '0;
            pwm_sample_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rec_len_q    <= rec_len_d;
            pwm_sample_q <= pwm_sample_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rec_len_d    = rec_len_q;
        pwm_sample_d = pwm_sample_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = addr_q;
        mem_wdata    = '0;
        deser_en     = 1'b0;
        pwm_en       = 1'b0;
        rec_done     = 1'b0;
        play_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rec_edge) begin
                    state_d   = RECORD;
                    addr_d    = '0;
                    rec_len_d = '0;
                end else if (play_edge) begin
                    state_d = PLAY_WAIT;
                    addr_d  = '0;
                end
            end

            RECORD: begin
                deser_en = 1'b1;
                if (sample_valid) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = sample_data;
                    addr_d    = addr_q + ONE;
                    rec_len_d = rec_len_q + ONE;
                end
                // A stop request still commits a sample arriving in the same cycle.
                if (rec_edge || (sample_valid && (addr_q == LAST_ADDR))) begin
                    rec_done = 1'b1;
                    state_d  = IDLE;
                end
            end

            PLAY_WAIT: begin
                if (play_edge || (rec_len_q == '0)) begin
                    play_done = 1'b1;
                    addr_d    = '0;
                    state_d   = IDLE;
                end else begin
                    pwm_en = 1'b1;
                    if (pwm_req) begin
                        state_d = PLAY_RD;
                    end
                end
            end

            PLAY_RD: begin
                pwm_en = 1'b1;
                if (play_edge) begin
                    play_done = 1'b1;
                    addr_d    = '0;
                    state_d   = IDLE;
                end else begin
                    mem_en  = 1'b1;
                    state_d = PLAY_LATCH;
                end
            end

            PLAY_LATCH: begin
                pwm_en = 1'b1;
                if (play_edge) begin
                    play_done = 1'b1;
                    addr_d    = '0;
                    state_d   = IDLE;
                end else begin
                    pwm_sample_d = mem_rdata;
                    if (addr_q == (rec_len_q - ONE)) begin
                        play_done = 1'b1;
                        addr_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        addr_d  = addr_q + ONE;
                        state_d = PLAY_WAIT;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign rec_len    = rec_len_q;
    assign pwm_sample = pwm_sample_q;

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Directed bench for audio_seq_ctrl: default-depth instance for record/play
// behaviour and a DEPTH=8 instance for the full-memory stop.
module tb_audio_seq_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Default-geometry instance
    logic        rec_btn = 1'b0, play_btn = 1'b0, sample_valid = 1'b0, pwm_req = 1'b0;
    logic [15:0] sample_data = '0;
    logic        deser_en, pwm_en, busy, rec_done, play_done;
    logic [15:0] pwm_sample;
    logic [16:0] rec_len;

    audio_seq_ctrl_if #(.AW(17), .DW(16)) bus0 ();

    audio_seq_ctrl #(.DEPTH(125000), .AW(17), .DW(16)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rec_btn      (rec_btn),
        .play_btn     (play_btn),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .pwm_req      (pwm_req),
        .mem_rdata    (bus0.mem_rdata),
        .mem_en       (bus0.mem_en),
        .mem_we       (bus0.mem_we),
        .mem_addr     (bus0.mem_addr),
        .mem_wdata    (bus0.mem_wdata),
        .deser_en     (deser_en),
        .pwm_en       (pwm_en),
        .pwm_sample   (pwm_sample),
        .rec_len      (rec_len),
        .busy         (busy),
        .rec_done     (rec_done),
        .play_done    (play_done)
    );

    logic [15:0] mem0 [0:131071];
    int wr_cnt0 = 0;
    int rd_cnt0 = 0;
    always @(posedge clk) begin
        if (bus0.mem_en) begin
            if (bus0.mem_we) begin
                mem0[bus0.mem_addr] <= bus0.mem_wdata;
                wr_cnt0 <= wr_cnt0 + 1;
            end else begin
                bus0.mem_rdata <= mem0[bus0.mem_addr];
                rd_cnt0 <= rd_cnt0 + 1;
            end
        end
    end

    // DEPTH=8 instance
    logic        rec8 = 1'b0, sv8 = 1'b0;
    logic [15:0] sd8 = '0;
    logic        deser_en8, pwm_en8, busy8, rec_done8, play_done8;
    logic [15:0] pwm_sample8;
    logic [3:0]  rec_len8;

    audio_seq_ctrl_if #(.AW(4), .DW(16)) bus8 ();

    audio_seq_ctrl #(.DEPTH(8), .AW(4), .DW(16)) u_dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rec_btn      (rec8),
        .play_btn     (1'b0),
        .sample_valid (sv8),
        .sample_data  (sd8),
        .pwm_req      (1'b0),
        .mem_rdata    (bus8.mem_rdata),
        .mem_en       (bus8.mem_en),
        .mem_we       (bus8.mem_we),
        .mem_addr     (bus8.mem_addr),
        .mem_wdata    (bus8.mem_wdata),
        .deser_en     (deser_en8),
        .pwm_en       (pwm_en8),
        .pwm_sample   (pwm_sample8),
        .rec_len      (rec_len8),
        .busy         (busy8),
        .rec_done     (rec_done8),
        .play_done    (play_done8)
    );

    logic [15:0] mem8 [0:15];
    int wr_cnt8 = 0;
    always @(posedge clk) begin
        if (bus8.mem_en) begin
            if (bus8.mem_we) begin
                mem8[bus8.mem_addr] <= bus8.mem_wdata;
                wr_cnt8 <= wr_cnt8 + 1;
            end else begin
                bus8.mem_rdata <= mem8[bus8.mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: pass the edge, apply this cycle's inputs, let combinational outputs settle.
    task automatic cyc(input logic r, input logic p, input logic v, input logic [15:0] d, input logic q);
        @(posedge clk);
        #1;
        rec_btn = r; play_btn = p; sample_valid = v; sample_data = d; pwm_req = q;
        #1;
    endtask

    task automatic cyc8(input logic r, input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        rec8 = r; sv8 = v; sd8 = d;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {busy, deser_en, pwm_en, bus0.mem_en, rec_done, play_done}, 0);
        check("reset_rec_len", rec_len, 0);
        check("reset_pwm_sample", pwm_sample, 0);

        // Button already high at reset release: ignored on edge 1, taken on edge 2
        reset_n = 1'b1;
        rec_btn = 1'b1;
        #1;
        cyc(1, 0, 0, 0, 0);
        check("no_accept_first_edge", busy, 0);
        cyc(1, 0, 0, 0, 0);
        check("accept_second_edge", {busy, deser_en}, 2'b11);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("empty_rec_stop_done", rec_done, 1);
        check("empty_rec_len", rec_len, 0);
        cyc(0, 0, 0, 0, 0);
        check("empty_rec_idle", {busy, rec_done}, 0);

        // Play with nothing recorded
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("empty_play_done", {play_done, busy, pwm_en, bus0.mem_en}, 4'b1100);
        cyc(0, 0, 0, 0, 0);
        check("empty_play_idle", {busy, play_done}, 0);
        check("empty_play_no_read", rd_cnt0, 0);

        // Simultaneous edges: record wins; play edge mid-record ignored
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rec_wins", {busy, deser_en, pwm_en}, 3'b110);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, (i == 3), 1, 16'(i), 0);
            check("rec_write", {bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata},
                  {1'b1, 1'b1, 17'(i - 1), 16'(i)});
        end
        cyc(0, 0, 0, 0, 0);
        check("play_ignored_in_rec", {busy, deser_en, rec_done}, 3'b110);
        check("rec_len_5", rec_len, 5);
        cyc(1, 0, 0, 0, 0);
        check("rec_stop_done", {rec_done, bus0.mem_en}, 2'b10);
        cyc(0, 0, 0, 0, 0);
        check("rec_stop_idle", {busy, rec_done}, 0);
        check("rec_len_kept", rec_len, 5);
        check("rec_write_count", wr_cnt0, 5);
        check("mem_word0", mem0[0], 16'h0001);
        check("mem_word4", mem0[4], 16'h0005);

        // Playback of the 5 samples, with one request dropped while reading
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("play_wait_entry", {busy, pwm_en, play_done}, 3'b110);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, (k == 2));
            check("play_read", {bus0.mem_en, bus0.mem_we, bus0.mem_addr}, {1'b1, 1'b0, 17'(k - 1)});
            cyc(0, 0, 0, 0, 0);
            check("play_done_pulse", play_done, (k == 5));
            cyc(0, 0, 0, 0, 0);
            check("play_sample", pwm_sample, 16'(k));
        end
        check("play_end_idle", busy, 0);
        check("play_read_count", rd_cnt0, 5);

        // Replay restarts at 0; rec edge ignored; play edge aborts
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("replay_first", pwm_sample, 16'h0001);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("rec_ignored_in_play", {busy, deser_en, pwm_en}, 3'b101);
        cyc(0, 1, 0, 0, 0);
        check("abort_done", play_done, 1);
        cyc(0, 0, 0, 0, 0);
        check("abort_idle", busy, 0);
        check("abort_keeps_rec_len", rec_len, 5);
        check("abort_holds_sample", pwm_sample, 16'h0001);
        check("abort_read_count", rd_cnt0, 6);

        // Reset in the middle of a recording at address 3
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 16'(16'hA0 + i), 0);
        end
        cyc(0, 0, 0, 0, 0);
        check("mid_rec_len_3", rec_len, 3);
        reset_n = 1'b0;
        #1;
        check("async_reset_outs", {busy, deser_en, pwm_en, bus0.mem_en, bus0.mem_we, rec_done, play_done}, 0);
        check("async_reset_rec_len", rec_len, 0);
        check("async_reset_pwm_sample", pwm_sample, 0);
        check("mid_rec_write_count", wr_cnt0, 8);

        // Full-memory stop on the DEPTH=8 instance
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc8(0, 0, 0);
        cyc8(1, 0, 0);
        cyc8(0, 0, 0);
        check("d8_record_entry", {busy8, deser_en8}, 2'b11);
        for (int i = 0; i < 10; i++) begin
            cyc8(0, 1, 16'(16'h0100 + i));
            if (i < 8) begin
                check("d8_write", {bus8.mem_en, bus8.mem_we, bus8.mem_addr, bus8.mem_wdata},
                      {1'b1, 1'b1, 4'(i), 16'(16'h0100 + i)});
                check("d8_rec_done", rec_done8, (i == 7));
            end else begin
                check("d8_no_write_after_full", {bus8.mem_en, busy8}, 0);
            end
        end
        cyc8(0, 0, 0);
        check("d8_rec_len", rec_len8, 8);
        check("d8_write_count", wr_cnt8, 8);
        check("d8_last_word", mem8[7], 16'h0107);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
